// File: rtl/sfm_pkg.sv
// Shared constants and request bundle for the softmax streamer TCDM path.
// Used by the TCDM responder and by streamer-side benches.
package sfm_pkg;

  localparam int unsigned SFM_TCDM_LFSR_W = 16;
  // taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [SFM_TCDM_LFSR_W-1:0] SFM_TCDM_LFSR_TAPS = 16'hB400;

  localparam int unsigned SFM_TCDM_DW = 256;
  localparam int unsigned SFM_TCDM_AW = 32;

  typedef struct packed {
    logic [SFM_TCDM_AW-1:0]   add;
    logic                     wen;
    logic [SFM_TCDM_DW/8-1:0] be;
    logic [SFM_TCDM_DW-1:0]   data;
  } tcdm_req_t;

  function automatic logic [SFM_TCDM_LFSR_W-1:0] sfm_lfsr_next(
    input logic [SFM_TCDM_LFSR_W-1:0] s
  );
    return {s[SFM_TCDM_LFSR_W-2:0], ^(s & SFM_TCDM_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sfm_lfsr_stall.sv
// Free-running Fibonacci LFSR producing a pseudo-random stall flag.
// Ports: clk_i, rst_ni, i_clear (reload seed), i_thr (threshold), o_stall.
module sfm_lfsr_stall
  import sfm_pkg::*;
#(
  parameter logic [SFM_TCDM_LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       i_clear,
  input  logic [3:0] i_thr,
  output logic       o_stall
);

  logic [SFM_TCDM_LFSR_W-1:0] r_lfsr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr <= SEED;
    end else if (i_clear) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= sfm_lfsr_next(r_lfsr);
    end
  end

  // threshold 0 can never be exceeded -> never stall
  assign o_stall = (r_lfsr[3:0] < i_thr);

endmodule

// File: rtl/sfm_tcdm_responder.sv
// TCDM slave memory with fixed read latency and random grant throttling.
// Ports: clk_i/rst_ni/clear_i, stall_thr_i, tcdm_* request/response, n_reads_o/n_writes_o.
module sfm_tcdm_responder
  import sfm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [SFM_TCDM_LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic [3:0]              stall_thr_i,
  input  logic                    tcdm_req_i,
  output logic                    tcdm_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   tcdm_add_i,
  input  logic                    tcdm_wen_i,
  input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
  input  logic [DATA_WIDTH-1:0]   tcdm_data_i,
  output logic [DATA_WIDTH-1:0]   tcdm_r_data_o,
  output logic                    tcdm_r_valid_o,
  output logic [31:0]             n_reads_o,
  output logic [31:0]             n_writes_o
);

  localparam int unsigned BW   = DATA_WIDTH / 8;
  localparam int unsigned OFFS = $clog2(BW);
  localparam int unsigned IW   = $clog2(DEPTH);

  logic                  w_stall;
  logic                  w_hs;
  logic                  w_rd_hs;
  logic                  w_wr_hs;
  logic [IW-1:0]         w_idx;
  logic                  w_last_v;
  logic [IW-1:0]         w_last_idx;
  logic                  w_unused;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [31:0]           r_nrd;
  logic [31:0]           r_nwr;

  sfm_lfsr_stall #(
    .SEED (LFSR_SEED)
  ) i_stall (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_clear (clear_i),
    .i_thr   (stall_thr_i),
    .o_stall (w_stall)
  );

  assign tcdm_gnt_o = tcdm_req_i & ~w_stall & ~clear_i;
  assign w_hs       = tcdm_req_i & tcdm_gnt_o;
  assign w_rd_hs    = w_hs & tcdm_wen_i;
  assign w_wr_hs    = w_hs & ~tcdm_wen_i;

  // byte offset and upper address bits are don't-care (wrap-around)
  assign w_idx    = tcdm_add_i[OFFS+IW-1:OFFS];
  assign w_unused = ^{tcdm_add_i[ADDR_WIDTH-1:OFFS+IW],
                      tcdm_add_i[OFFS-1:0]};

  // w_last_* is the read that gets its data at the coming edge
  if (READ_LATENCY == 1) begin : g_lat1
    assign w_last_v   = w_rd_hs;
    assign w_last_idx = w_idx;
  end else begin : g_pipe
    localparam int unsigned S = READ_LATENCY - 1;

    logic [S-1:0]  r_pv;
    logic [IW-1:0] r_pidx [S];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_pv <= '0;
        for (int i = 0; i < S; i++) begin
          r_pidx[i] <= '0;
        end
      end else if (clear_i) begin
        r_pv <= '0;
      end else begin
        r_pv[0]   <= w_rd_hs;
        r_pidx[0] <= w_idx;
        for (int i = 1; i < S; i++) begin
          r_pv[i]   <= r_pv[i-1];
          r_pidx[i] <= r_pidx[i-1];
        end
      end
    end

    assign w_last_v   = r_pv[S-1];
    assign w_last_idx = r_pidx[S-1];
  end

  // memory is read only at the last stage so in-flight reads
  // observe every write accepted before that point
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_rdata <= '0;
    end else if (clear_i) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_last_v;
      if (w_last_v) begin
        r_rdata <= r_mem[w_last_idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_hs) begin
      for (int b = 0; b < BW; b++) begin
        if (tcdm_be_i[b]) begin
          r_mem[w_idx][b*8 +: 8] <= tcdm_data_i[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_nrd <= '0;
      r_nwr <= '0;
    end else if (clear_i) begin
      r_nrd <= '0;
      r_nwr <= '0;
    end else begin
      if (w_rd_hs && (r_nrd != 32'hFFFF_FFFF)) begin
        r_nrd <= r_nrd + 32'd1;
      end
      if (w_wr_hs && (r_nwr != 32'hFFFF_FFFF)) begin
        r_nwr <= r_nwr + 32'd1;
      end
    end
  end

  assign tcdm_r_valid_o = r_valid;
  assign tcdm_r_data_o  = r_rdata;
  assign n_reads_o      = r_nrd;
  assign n_writes_o     = r_nwr;

endmodule

// File: tb/tb_sfm_tcdm_responder.sv
// Bench for sfm_tcdm_responder: vector table, hand sequences, scoreboard.
// Ports of the DUT are all driven/observed from here.
module tb_sfm_tcdm_responder;
  import sfm_pkg::*;

  localparam int DW    = 256;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int L     = 3;
  localparam int BW    = DW / 8;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam logic [DW-1:0] Z    = '0;
  localparam logic [DW-1:0] ONES = '1;
  localparam logic [DW-1:0] A5   = {32{8'hA5}};
  localparam logic [DW-1:0] PAT  = {8{32'hDEAD0001}};
  localparam logic [DW-1:0] B0Z  = {{31{8'hFF}}, 8'h00};
  localparam logic [DW-1:0] HALF = {{16{8'h00}}, {16{8'hA5}}};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic [3:0]    thr = '0;
  logic          req = 1'b0;
  logic          wen = 1'b1;
  logic [AW-1:0] add = '0;
  logic [BW-1:0] be = '0;
  logic [DW-1:0] wdata = '0;
  logic          gnt;
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic [31:0]   n_rd;
  logic [31:0]   n_wr;

  sfm_tcdm_responder #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .DEPTH        (DEPTH),
    .READ_LATENCY (L),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clear_i        (clear),
    .stall_thr_i    (thr),
    .tcdm_req_i     (req),
    .tcdm_gnt_o     (gnt),
    .tcdm_add_i     (add),
    .tcdm_wen_i     (wen),
    .tcdm_be_i      (be),
    .tcdm_data_i    (wdata),
    .tcdm_r_data_o  (r_data),
    .tcdm_r_valid_o (r_valid),
    .n_reads_o      (n_rd),
    .n_writes_o     (n_wr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else if (clear) m_lfsr <= SEED;
    else m_lfsr <= {m_lfsr[14:0],
                    m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    int            idx;
    int            due;
    logic [DW-1:0] data;
    bit            snapped;
  } sb_t;

  sb_t           sb[$];
  logic [DW-1:0] mmem [DEPTH];
  int            m_nrd = 0;
  int            m_nwr = 0;
  int            n_vld = 0;
  logic [DW-1:0] last_rd = '0;

  function automatic int word_of(input logic [AW-1:0] a);
    return int'((a >> 5) % DEPTH);
  endfunction

  initial begin : monitor
    sb_t e;
    bit  eg;
    bit  hs;
    int  wi;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        last_rd = '0;
        m_nrd = 0;
        m_nwr = 0;
      end else begin
        eg = req && !clear && !(m_lfsr[3:0] < thr);
        chk("gnt", gnt, eg);
        chk("n_reads", n_rd, m_nrd);
        chk("n_writes", n_wr, m_nwr);
        if (r_valid) begin
          n_vld++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rvalid_spurious: r_valid=1 at cycle %0d, expected 0", cyc);
            last_rd = r_data;
          end else begin
            e = sb.pop_front();
            chk("rvalid_cycle", cyc, e.due);
            chk("r_data", r_data, e.data);
            last_rd = e.data;
          end
        end else begin
          if (sb.size() != 0 && sb[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL rvalid_missing: r_valid=0 at cycle %0d, expected 1", cyc);
            void'(sb.pop_front());
          end
          chk("r_data_hold", r_data, last_rd);
        end
        hs = req && gnt;
        wi = word_of(add);
        if (clear) begin
          sb.delete();
          m_nrd = 0;
          m_nwr = 0;
        end else if (hs && wen) begin
          e.idx = wi;
          e.due = cyc + L;
          e.data = '0;
          e.snapped = 1'b0;
          sb.push_back(e);
          m_nrd++;
        end else if (hs) begin
          m_nwr++;
        end
        for (int i = 0; i < sb.size(); i++) begin
          if (!sb[i].snapped && sb[i].due == cyc + 1) begin
            sb[i].data = mmem[sb[i].idx];
            sb[i].snapped = 1'b1;
          end
        end
        if (hs && !wen && !clear) begin
          for (int b = 0; b < BW; b++) begin
            if (be[b]) mmem[wi][b*8 +: 8] = wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  task automatic do_req(input logic w, input logic [AW-1:0] a,
                        input logic [BW-1:0] b, input logic [DW-1:0] d);
    int n;
    n = 0;
    req = 1'b1;
    wen = w;
    add = a;
    be = b;
    wdata = d;
    forever begin
      @(negedge clk);
      if (gnt) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL gnt_timeout: no grant in 200 cycles, expected grant");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = 1'b0;
  endtask

  task automatic pulse_clear();
    req = 1'b0;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic rd_check(input string nm, input logic [AW-1:0] a,
                          input logic [DW-1:0] exp);
    do_req(1'b1, a, '0, '0);
    idle();
    repeat (L - 1) @(posedge clk);
    @(negedge clk);
    chk({nm, "_rvalid"}, r_valid, 1'b1);
    chk({nm, "_data"}, r_data, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic rec(output logic [63:0] v);
    req = 1'b1;
    wen = 1'b1;
    add = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      v[i] = gnt;
      @(posedge clk);
      #1;
    end
    req = 1'b0;
  endtask

  function automatic logic [63:0] exp_gnt(input logic [3:0] t);
    logic [15:0] s;
    logic [63:0] v;
    s = SEED;
    for (int i = 0; i < 64; i++) begin
      v[i] = !(s[3:0] < t);
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    end
    return v;
  endfunction

  typedef struct {
    tcdm_req_t     rq;
    logic [DW-1:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [AW-1:0] a,
                              input logic [BW-1:0] b,
                              input logic [DW-1:0] d,
                              input logic [DW-1:0] x);
    vec_t v;
    v.rq.wen = w;
    v.rq.add = a;
    v.rq.be = b;
    v.rq.data = d;
    v.exp = x;
    return v;
  endfunction

  vec_t vt[10];

  initial begin : main
    logic [DW-1:0] d;
    logic [63:0]   v1;
    logic [63:0]   v2;
    logic [63:0]   ev;
    int            nv;
    int            c0;
    int            ncyc;

    vt[0] = mk(1'b0, 32'h40, '1, A5, Z);
    vt[1] = mk(1'b1, 32'h40, '0, Z, A5);
    vt[2] = mk(1'b0, 32'h80, '1, ONES, Z);
    vt[3] = mk(1'b0, 32'h80, 32'h1, Z, Z);
    vt[4] = mk(1'b1, 32'h80, '0, Z, B0Z);
    vt[5] = mk(1'b0, 32'h8020, '1, PAT, Z);
    vt[6] = mk(1'b1, 32'h20, '0, Z, PAT);
    vt[7] = mk(1'b1, 32'h5F, '0, Z, A5);
    vt[8] = mk(1'b0, 32'hFFFF8040, 32'hFFFF0000, Z, Z);
    vt[9] = mk(1'b1, 32'h40, '0, Z, HALF);

    repeat (2) @(negedge clk);
    chk("reset_rvalid", r_valid, 1'b0);
    chk("reset_rdata", r_data, Z);
    chk("reset_nreads", n_rd, 32'd0);
    chk("reset_nwrites", n_wr, 32'd0);
    chk("reset_gnt", gnt, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    thr = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (vt[i].rq.wen) begin
        rd_check($sformatf("vec%0d", i), vt[i].rq.add, vt[i].exp);
      end else begin
        do_req(1'b0, vt[i].rq.add, vt[i].rq.be, vt[i].rq.data);
      end
    end
    idle();

    do_req(1'b1, 32'h40, '0, Z);
    do_req(1'b1, 32'h80, '0, Z);
    pulse_clear();
    nv = n_vld;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("clear_no_rvalid", n_vld - nv, 0);
    chk("clear_nreads", n_rd, 32'd0);
    chk("clear_nwrites", n_wr, 32'd0);
    @(posedge clk);
    #1;
    rd_check("clear_mem", 32'h40, HALF);

    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      do_req(1'b0, i * 32, '1, d);
    end
    idle();
    pulse_clear();
    nv = n_vld;
    for (int i = 0; i < 8; i++) do_req(1'b1, i * 32, '0, Z);
    idle();
    repeat (L + 2) @(posedge clk);
    @(negedge clk);
    chk("b2b_nreads", n_rd, 32'd8);
    chk("b2b_rvalid_count", n_vld - nv, 8);
    @(posedge clk);
    #1;

    thr = 4'd8;
    c0 = cyc;
    for (int i = 0; i < 1000; i++) begin
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      do_req(1'($urandom_range(0, 1)),
             AW'(($urandom_range(0, 15) << 5) | $urandom_range(0, 31)),
             BW'($urandom), d);
    end
    idle();
    ncyc = cyc - c0;
    checks++;
    if (ncyc < 1667 || ncyc > 2500) begin
      errors++;
      $display("FAIL stall_ratio: 1000 grants took %0d cycles, expected 1667..2500", ncyc);
    end
    repeat (L + 2) @(posedge clk);
    #1;
    chk("stall_sb_drain", sb.size(), 0);

    ev = exp_gnt(4'd8);
    pulse_clear();
    rec(v1);
    pulse_clear();
    rec(v2);
    chk("clear_seq1", v1, ev);
    chk("clear_seq2", v2, ev);
    repeat (L + 2) @(posedge clk);
    #1;

    thr = 4'd0;
    nv = n_vld;
    do_req(1'b1, 32'h40, '0, Z);
    idle();
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("areset_no_rvalid", n_vld - nv, 0);
    chk("areset_rdata", r_data, Z);
    chk("areset_nreads", n_rd, 32'd0);
    chk("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
